// File: rtl/stack_pkg.sv
// Shared encodings for the data-stack controller: op codes and error codes.
package stack_pkg;

    typedef enum logic [1:0] {
        OP_NOP     = 2'd0,
        OP_PUSH    = 2'd1,
        OP_POP     = 2'd2,
        OP_REPLACE = 2'd3
    } op_t;

    typedef enum logic [1:0] {
        ERR_NONE = 2'd0,
        ERR_OVF  = 2'd1,
        ERR_UDF  = 2'd2
    } err_t;

endpackage

// File: rtl/stack_ctl.sv
// Data-stack controller: TOS cached in a register, deeper entries in an
// external single-port RAM at addresses 0..depth-2. One op per cycle.
module stack_ctl
    import stack_pkg::*;
#(
    parameter int unsigned WIDTH      = 16,
    parameter int unsigned ADDR_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  clear,
    input  logic                  op_valid,
    input  logic [1:0]            op,
    input  logic [WIDTH-1:0]      push_data,
    output logic [WIDTH-1:0]      tos,
    output logic [WIDTH-1:0]      nos,
    output logic [ADDR_WIDTH:0]   depth,
    output logic                  empty,
    output logic                  full,
    output logic                  err,
    output logic [1:0]            err_code,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [WIDTH-1:0]      mem_din,
    output logic                  mem_we,
    input  logic [WIDTH-1:0]      mem_dout
);

    localparam logic [ADDR_WIDTH:0] CAP = {1'b1, {ADDR_WIDTH{1'b0}}};
    localparam logic [ADDR_WIDTH:0] ONE = {{ADDR_WIDTH{1'b0}}, 1'b1};
    localparam logic [ADDR_WIDTH:0] TWO = {{(ADDR_WIDTH-1){1'b0}}, 2'b10};

    logic [WIDTH-1:0]    r_tos;
    logic [ADDR_WIDTH:0] r_depth;
    logic                r_err;
    logic [1:0]          r_err_code;

    logic [WIDTH-1:0]    w_tos_nxt;
    logic [ADDR_WIDTH:0] w_depth_nxt;
    logic [ADDR_WIDTH:0] w_depth_m1;
    logic [ADDR_WIDTH:0] w_depth_m2;
    logic                w_empty;
    logic                w_full;
    logic                w_ge2;
    logic                w_push_req;
    logic                w_op_act;
    logic                w_ovf;
    logic                w_udf;

    // Status decode, RAM port drive and error detection.
    always_comb begin
        w_empty    = (r_depth == '0);
        w_full     = (r_depth == CAP);
        w_ge2      = (r_depth >= TWO);
        w_depth_m1 = r_depth - ONE;
        w_depth_m2 = r_depth - TWO;
        w_push_req = op_valid && (op == OP_PUSH);
        w_op_act   = op_valid && !clear;

        // Push spills the old TOS to slot depth-1; otherwise present slot
        // depth-2 so NOS/POP see the entry under TOS (wraps when depth<2).
        if (w_push_req && !w_empty)
            mem_addr = w_depth_m1[ADDR_WIDTH-1:0];
        else
            mem_addr = w_depth_m2[ADDR_WIDTH-1:0];

        mem_din = r_tos;
        mem_we  = w_push_req && !clear && !rst && !w_empty && !w_full;

        w_ovf = w_op_act && (op == OP_PUSH) && w_full;
        w_udf = w_op_act && ((op == OP_POP) || (op == OP_REPLACE)) && w_empty;
    end

    // Next TOS/depth for the current op; clear wins over op.
    always_comb begin
        w_tos_nxt   = r_tos;
        w_depth_nxt = r_depth;
        if (clear) begin
            w_tos_nxt   = '0;
            w_depth_nxt = '0;
        end else if (op_valid) begin
            case (op)
                OP_PUSH: begin
                    if (!w_full) begin
                        w_tos_nxt   = push_data;
                        w_depth_nxt = r_depth + ONE;
                    end
                end
                OP_POP: begin
                    if (w_ge2) begin
                        w_tos_nxt   = mem_dout;
                        w_depth_nxt = w_depth_m1;
                    end else if (!w_empty) begin
                        w_tos_nxt   = '0;
                        w_depth_nxt = '0;
                    end
                end
                OP_REPLACE: begin
                    if (!w_empty)
                        w_tos_nxt = push_data;
                end
                default: ;
            endcase
        end
    end

    // State registers with synchronous reset; error status is sticky.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_tos      <= '0;
            r_depth    <= '0;
            r_err      <= 1'b0;
            r_err_code <= ERR_NONE;
        end else begin
            r_tos   <= w_tos_nxt;
            r_depth <= w_depth_nxt;
            if (!r_err && (w_ovf || w_udf)) begin
                r_err      <= 1'b1;
                r_err_code <= w_ovf ? ERR_OVF : ERR_UDF;
            end
        end
    end

    assign tos      = r_tos;
    assign nos      = mem_dout;
    assign depth    = r_depth;
    assign empty    = w_empty;
    assign full     = w_full;
    assign err      = r_err;
    assign err_code = r_err_code;

endmodule
